// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM controller status and memory arbiter states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DREAD  = 2'd1,
    DWRITE = 2'd2,
    IREAD  = 2'd3
  } arbstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises dcache read/write and icache read requests onto the single-port RAM.
// Optional MEMARB_TIMEOUT_EN aborts a transaction left TIMEOUT cycles without ACCESS (merr pulse).
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      merr,
  output arbstate_t state_o
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1) begin : g_bad_params
    $error("mem_arbiter: STARVE_MAX must be 1..15 and TIMEOUT at least 1");
  end

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  // Handshake: a request bit is "valid", its wait line is an inverted "ready".
  // The transfer completes in the single cycle the wait line is low; the requester
  // holds address/data stable until then and may withdraw (drop the bit) before it.

  arbstate_t  state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       done;
  logic       own_req;
  logic       tmo_hit;

`ifdef MEMARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
`ifdef MEMARB_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
`ifdef MEMARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    done     = (ramstate == ACCESS);
    tmo_hit  = 1'b0;

    case (state_q)
      DREAD:   own_req = dREN;
      DWRITE:  own_req = dWEN;
      IREAD:   own_req = iREN;
      default: own_req = 1'b0;
    endcase

`ifdef MEMARB_TIMEOUT_EN
    tmo_d   = (state_q == IDLE) ? '0 : tmo_q + TW'(1);
    tmo_hit = (state_q != IDLE) && !done && (tmo_q == TmoLast);
`endif
    merr = tmo_hit;

    case (state_q)
      IDLE: begin
        // The icache is forced ahead once the dcache has been granted StarveMax times in a row.
        if (iREN && ((starve_q == StarveMax) || !(dREN || dWEN))) begin
          state_d  = IREAD;
          starve_d = '0;
        end else if (dWEN || dREN) begin
          state_d  = dWEN ? DWRITE : DREAD;
          starve_d = iREN ? starve_q + 4'd1 : '0;
        end else begin
          starve_d = '0;
        end
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr;
        dwait   = !done;
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !done;
      end
      IREAD: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = !done;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && (done || !own_req || tmo_hit)) begin
      state_d = IDLE;
    end
  end

  assign iload   = ramload;
  assign dload   = ramload;
  assign state_o = state_q;

endmodule
